// File: rtl/ov7670_pkg.sv
// ----------------------------------------------------------------------------
// ov7670_pkg
// Shared types for the OV7670 pattern source: test-pattern selector, frame
// sequencer states, the 12-bit RGB444 pixel type, and the helper that splits
// one pixel into the two bytes the camera sends.
// ----------------------------------------------------------------------------
package ov7670_pkg;

    typedef enum logic [1:0] {
        PAT_SOLID,
        PAT_BARS,
        PAT_ZEBRA,
        PAT_GRAD
    } pattern_e;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } src_state_e;

    typedef logic [11:0] rgb444_t;

    // Pixel coordinate widths seen by the pattern generator. They are fixed
    // wide enough for the gradient pattern's x[9:6] / y[8:5] taps.
    localparam int X_W = 10;
    localparam int Y_W = 9;

    // The camera sends RGB444 as two bytes: the first carries R in the low
    // nibble with the high nibble zero, the second carries {G, B}.
    function automatic logic [7:0] pack_rgb444_byte(rgb444_t rgb, logic phase);
        return phase ? rgb[7:0] : {4'h0, rgb[11:8]};
    endfunction

endpackage

// File: rtl/pattern_pixel_gen.sv
// ----------------------------------------------------------------------------
// pattern_pixel_gen
// Purely combinational colour lookup for one pixel of the test pattern.
// Ports:
//   x_i          pixel column
//   y_i          pixel row
//   pattern_i    pattern selector (pattern_e encoding)
//   frameCount_i completed-frame count, low nibble feeds the gradient blue
//   bar_i        colour-bar index supplied by the caller's bar counter
//   stripeOdd_i  high while the current row lies in an odd zebra stripe
//   rgb_o        resulting 12-bit {R,G,B}
// ----------------------------------------------------------------------------
module pattern_pixel_gen
    import ov7670_pkg::*;
(
    input  logic [X_W-1:0] x_i,
    input  logic [Y_W-1:0] y_i,
    input  logic [1:0]     pattern_i,
    input  logic [15:0]    frameCount_i,
    input  logic [2:0]     bar_i,
    input  logic           stripeOdd_i,
    output logic [11:0]    rgb_o
);

    // Bars and stripes arrive precomputed from counters in the sequencer, so
    // nothing here needs a divider. The gradient uses fixed coarse taps of
    // the coordinates, taken through shifts of the full coordinate words.
    always_comb begin
        rgb_o = 12'h000;
        case (pattern_e'(pattern_i))
            PAT_SOLID: rgb_o = 12'hFFF;
            PAT_BARS:  rgb_o = {{4{bar_i[2]}}, {4{bar_i[1]}}, {4{bar_i[0]}}};
            PAT_ZEBRA: rgb_o = stripeOdd_i ? 12'h000 : 12'hFFF;
            PAT_GRAD:  rgb_o = {4'(x_i >> 6), 4'(y_i >> 5), 4'(frameCount_i)};
            default:   rgb_o = 12'h000;
        endcase
    end

endmodule

// File: rtl/ov7670_pattern_source.sv
// ----------------------------------------------------------------------------
// ov7670_pattern_source
// Synthesizable stand-in for the OV7670 sensor: produces VSYNC/HREF/DATA in
// RGB444 two-bytes-per-pixel format, one byte per clock.
// Ports:
//   clk_i          byte clock (the consumer's pclk is the same clock)
//   rst_i          synchronous active-high reset
//   enable_i       frames keep running while high
//   pattern_sel_i  0 solid white, 1 colour bars, 2 zebra, 3 gradient
//   vsync_o        frame sync, high during the sync lines
//   href_o         high for active data bytes
//   d_o            data byte
//   frame_done_o   one-cycle pulse when a frame finishes
//   frame_count_o  completed frame count, wraps at 16 bits
// ----------------------------------------------------------------------------
module ov7670_pattern_source
    import ov7670_pkg::*;
#(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int H_BLANK     = 144,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 17,
    parameter int V_FRONT     = 10,
    parameter int STRIPE_H    = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic [1:0]  pattern_sel_i,
    output logic        vsync_o,
    output logic        href_o,
    output logic [7:0]  d_o,
    output logic        frame_done_o,
    output logic [15:0] frame_count_o
);

    localparam int LINE_LEN  = 2 * IMG_WIDTH + H_BLANK;
    localparam int COL_W     = $clog2(LINE_LEN);
    localparam int MAX_A     = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int MAX_B     = (IMG_HEIGHT > V_FRONT) ? IMG_HEIGHT : V_FRONT;
    localparam int MAX_LINES = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int LN_W      = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int BAR_BYTES = IMG_WIDTH / 4;
    localparam int BCNT_W    = $clog2(BAR_BYTES);
    localparam int STR_W     = (STRIPE_H > 1) ? $clog2(STRIPE_H) : 1;

    localparam logic [COL_W-1:0]  COL_LAST      = COL_W'(LINE_LEN - 1);
    localparam logic [COL_W-1:0]  COL_HREF_END  = COL_W'(2 * IMG_WIDTH);
    localparam logic [LN_W-1:0]   LN_VSYNC_LAST = LN_W'(VSYNC_LINES - 1);
    localparam logic [LN_W-1:0]   LN_VBACK_LAST = LN_W'(V_BACK - 1);
    localparam logic [LN_W-1:0]   LN_ACT_LAST   = LN_W'(IMG_HEIGHT - 1);
    localparam logic [LN_W-1:0]   LN_VFRNT_LAST = LN_W'(V_FRONT - 1);
    localparam logic [BCNT_W-1:0] BCNT_LAST     = BCNT_W'(BAR_BYTES - 1);
    localparam logic [STR_W-1:0]  STR_LAST      = STR_W'(STRIPE_H - 1);

    src_state_e        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [LN_W-1:0]   ln_q, ln_d;
    logic [BCNT_W-1:0] barCnt_q, barCnt_d;
    logic [2:0]        bar_q, bar_d;
    logic [STR_W-1:0]  stripeCnt_q, stripeCnt_d;
    logic              stripeOdd_q, stripeOdd_d;
    logic [1:0]        pattern_q, pattern_d;
    logic [15:0]       frameCount_q, frameCount_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic [7:0]        data_q, data_d;
    logic              frameDone_q, frameDone_d;

    logic              lastLine;
    logic              frameEnd;
    logic [X_W-1:0]    pixX;
    logic [Y_W-1:0]    pixY;
    logic [11:0]       pixRgb;

    // State, counters and outputs all advance together. Outputs are computed
    // from the next-state values so that the registered pins line up with
    // the state they describe, and reset clears everything so an aborted
    // frame can never produce a frame_done.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            col_q        <= '0;
            ln_q         <= '0;
            barCnt_q     <= '0;
            bar_q        <= '0;
            stripeCnt_q  <= '0;
            stripeOdd_q  <= 1'b0;
            pattern_q    <= '0;
            frameCount_q <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            frameDone_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            ln_q         <= ln_d;
            barCnt_q     <= barCnt_d;
            bar_q        <= bar_d;
            stripeCnt_q  <= stripeCnt_d;
            stripeOdd_q  <= stripeOdd_d;
            pattern_q    <= pattern_d;
            frameCount_q <= frameCount_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            frameDone_q  <= frameDone_d;
        end
    end

    // Frame sequencer. Each non-idle state lasts a whole number of lines;
    // the column counter wraps every line and the line counter restarts in
    // every state. Zero-length blanking states are skipped at elaboration
    // time by the constant conditions. A frame ends on leaving the last
    // blanking state, and the enable sampled on that cycle picks whether
    // the next frame starts straight away.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        ln_d         = ln_q;
        pattern_d    = pattern_q;
        frameEnd     = 1'b0;
        lastLine     = 1'b0;

        case (state_q)
            VSYNC:   lastLine = (ln_q == LN_VSYNC_LAST);
            VBACK:   lastLine = (ln_q == LN_VBACK_LAST);
            ACTIVE:  lastLine = (ln_q == LN_ACT_LAST);
            VFRONT:  lastLine = (ln_q == LN_VFRNT_LAST);
            default: lastLine = 1'b0;
        endcase

        if (state_q == IDLE) begin
            col_d = '0;
            ln_d  = '0;
            if (enable_i) begin
                state_d = VSYNC;
            end
        end else if (col_q == COL_LAST) begin
            col_d = '0;
            if (lastLine) begin
                ln_d = '0;
                case (state_q)
                    VSYNC:  state_d = (V_BACK > 0) ? VBACK : ACTIVE;
                    VBACK:  state_d = ACTIVE;
                    ACTIVE: begin
                        if (V_FRONT > 0) begin
                            state_d = VFRONT;
                        end else begin
                            frameEnd = 1'b1;
                            state_d  = enable_i ? VSYNC : IDLE;
                        end
                    end
                    VFRONT: begin
                        frameEnd = 1'b1;
                        state_d  = enable_i ? VSYNC : IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end else begin
                ln_d = ln_q + LN_W'(1);
            end
        end else begin
            col_d = col_q + COL_W'(1);
        end

        if ((state_d == VSYNC) && (state_q != VSYNC)) begin
            pattern_d = pattern_sel_i;
        end

        frameCount_d = frameCount_q + 16'(frameEnd);
    end

    // Bar and stripe trackers replace division by the bar width and stripe
    // height. The bar counter follows the next column so it is aligned with
    // the byte being produced; the stripe counter restarts on entering the
    // active region and steps once per completed active line.
    always_comb begin
        barCnt_d    = barCnt_q;
        bar_d       = bar_q;
        stripeCnt_d = stripeCnt_q;
        stripeOdd_d = stripeOdd_q;

        if (col_d == '0) begin
            barCnt_d = '0;
            bar_d    = '0;
        end else if (barCnt_q == BCNT_LAST) begin
            barCnt_d = '0;
            bar_d    = bar_q + 3'd1;
        end else begin
            barCnt_d = barCnt_q + BCNT_W'(1);
        end

        if ((state_d == ACTIVE) && (state_q != ACTIVE)) begin
            stripeCnt_d = '0;
            stripeOdd_d = 1'b0;
        end else if ((state_q == ACTIVE) && (col_q == COL_LAST)) begin
            if (stripeCnt_q == STR_LAST) begin
                stripeCnt_d = '0;
                stripeOdd_d = ~stripeOdd_q;
            end else begin
                stripeCnt_d = stripeCnt_q + STR_W'(1);
            end
        end
    end

    pattern_pixel_gen u_pixel_gen (
        .x_i          (pixX),
        .y_i          (pixY),
        .pattern_i    (pattern_q),
        .frameCount_i (frameCount_q),
        .bar_i        (bar_d),
        .stripeOdd_i  (stripeOdd_d),
        .rgb_o        (pixRgb)
    );

    // Output decode from the next-state values. Even columns carry the R
    // byte and odd columns the {G,B} byte; data is forced to zero whenever
    // href is low.
    always_comb begin
        pixX        = X_W'(col_d >> 1);
        pixY        = Y_W'(ln_d);
        vsync_d     = (state_d == VSYNC);
        href_d      = (state_d == ACTIVE) && (col_d < COL_HREF_END);
        data_d      = href_d ? pack_rgb444_byte(pixRgb, col_d[0]) : 8'h00;
        frameDone_d = frameEnd;
    end

    assign vsync_o       = vsync_q;
    assign href_o        = href_q;
    assign d_o           = data_q;
    assign frame_done_o  = frameDone_q;
    assign frame_count_o = frameCount_q;

endmodule

// File: tb/tb_ov7670_pattern_source.sv
// ----------------------------------------------------------------------------
// tb_ov7670_pattern_source
// Directed bench for the pattern source in a small 8x4 configuration
// (20-cycle lines, 140-cycle frames). Expected pixels are queued when a
// frame is launched and checked as byte pairs are reassembled.
// ----------------------------------------------------------------------------
module tb_ov7670_pattern_source;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;
    localparam int SH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  patternSel;
    logic        vsync;
    logic        href;
    logic [7:0]  d;
    logic        frameDone;
    logic [15:0] frameCount;

    int          checks = 0;
    int          failures = 0;
    int          pixWrites = 0;
    int          doneCount = 0;
    logic [11:0] expQ[$];
    logic [7:0]  evenByte = 8'h00;
    logic        phase = 1'b0;
    logic        hrefPrev = 1'b0;
    logic [11:0] expPix;

    always #5 clk = ~clk;

    ov7670_pattern_source #(
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H),
        .H_BLANK     (HB),
        .VSYNC_LINES (VS),
        .V_BACK      (VB),
        .V_FRONT     (VF),
        .STRIPE_H    (SH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (enable),
        .pattern_sel_i (patternSel),
        .vsync_o       (vsync),
        .href_o        (href),
        .d_o           (d),
        .frame_done_o  (frameDone),
        .frame_count_o (frameCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [11:0] modelPixel(input logic [1:0] pat, input int x, input int y,
                                               input logic [15:0] fc);
        logic [2:0]  b;
        logic [11:0] r;
        b = 3'(x / (W / 8));
        case (pat)
            2'd0:    r = 12'hFFF;
            2'd1:    r = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
            2'd2:    r = (((y / SH) % 2) == 0) ? 12'hFFF : 12'h000;
            default: r = {4'(x / 64), 4'(y / 32), fc[3:0]};
        endcase
        return r;
    endfunction

    task automatic pushFrame(input logic [1:0] pat, input logic [15:0] fc);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                expQ.push_back(modelPixel(pat, x, y, fc));
            end
        end
    endtask

    task automatic applyStimulus(input logic [1:0] pat, input logic en);
        patternSel = pat;
        enable     = en;
    endtask

    task automatic waitFrameDone();
        int cyc = 0;
        while (frameDone !== 1'b1 && cyc < 2000) begin
            cyc++;
            @(negedge clk);
        end
        checkOutput("frame_done seen", 32'(frameDone), 1);
    endtask

    task automatic waitHref();
        int cyc = 0;
        while (href !== 1'b1 && cyc < 500) begin
            cyc++;
            @(negedge clk);
        end
        checkOutput("href seen", 32'(href), 1);
    endtask

    // Pixel reassembly and scoreboard: pairs of href bytes become one
    // RGB444 pixel, which is compared with the oldest queued expectation.
    // Outside href the data bus must be idle.
    always @(negedge clk) begin
        if (rst) begin
            phase = 1'b0;
        end else if (href) begin
            if (!hrefPrev) phase = 1'b0;
            if (!phase) begin
                evenByte = d;
                phase    = 1'b1;
            end else begin
                phase = 1'b0;
                pixWrites++;
                if (expQ.size() == 0) begin
                    checkOutput("scoreboard underflow", 32'(expQ.size()), 1);
                end else begin
                    expPix = expQ.pop_front();
                    checkOutput("pixel", {16'h0, evenByte, d}, {20'h0, expPix});
                end
            end
        end else begin
            checkOutput("blank data", 32'(d), 0);
        end
        if (!rst && frameDone) doneCount++;
        hrefPrev = href;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int n;
        int vsyncSeen;

        rst = 1'b1;
        applyStimulus(2'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset vsync", 32'(vsync), 0);
        checkOutput("reset href", 32'(href), 0);
        checkOutput("reset d", 32'(d), 0);
        checkOutput("reset frame_done", 32'(frameDone), 0);
        checkOutput("reset frame_count", 32'(frameCount), 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] solid frame timing");
        pixWrites = 0;
        pushFrame(2'd0, 16'd0);
        applyStimulus(2'd0, 1'b1);
        @(negedge clk);
        checkOutput("vsync after enable", 32'(vsync), 1);
        applyStimulus(2'd0, 1'b0);
        t = 0;
        while (vsync === 1'b1 && t < 500) begin t++; @(negedge clk); end
        checkOutput("vsync width", t, 20);
        while (href !== 1'b1 && t < 500) begin t++; @(negedge clk); end
        checkOutput("href rise offset", t, 40);
        n = 0;
        while (href === 1'b1 && n < 100) begin n++; t++; @(negedge clk); end
        checkOutput("href length", n, 16);
        while (frameDone !== 1'b1 && t < 1000) begin t++; @(negedge clk); end
        checkOutput("frame_done time", t, 140);
        checkOutput("frame_count 1", 32'(frameCount), 1);
        checkOutput("idle vsync", 32'(vsync), 0);
        @(negedge clk);
        checkOutput("frame_done pulse width", 32'(frameDone), 0);
        checkOutput("solid pixel writes", pixWrites, 32);
        checkOutput("solid drained", 32'(expQ.size()), 0);

        $display("[TB] colour bars");
        pixWrites = 0;
        pushFrame(2'd1, 16'd1);
        applyStimulus(2'd1, 1'b1);
        @(negedge clk);
        applyStimulus(2'd1, 1'b0);
        waitFrameDone();
        checkOutput("frame_count 2", 32'(frameCount), 2);
        checkOutput("bars pixel writes", pixWrites, 32);
        checkOutput("bars drained", 32'(expQ.size()), 0);
        @(negedge clk);

        $display("[TB] zebra with mid-frame pattern change");
        pixWrites = 0;
        pushFrame(2'd2, 16'd2);
        applyStimulus(2'd2, 1'b1);
        waitHref();
        applyStimulus(2'd0, 1'b1);
        pushFrame(2'd0, 16'd3);
        waitFrameDone();
        checkOutput("frame_count 3", 32'(frameCount), 3);
        checkOutput("back-to-back vsync", 32'(vsync), 1);
        applyStimulus(2'd0, 1'b0);
        @(negedge clk);
        waitFrameDone();
        checkOutput("frame_count 4", 32'(frameCount), 4);
        checkOutput("two-frame pixel writes", pixWrites, 64);
        checkOutput("zebra drained", 32'(expQ.size()), 0);
        @(negedge clk);
        checkOutput("vsync after stop", 32'(vsync), 0);

        $display("[TB] enable dropped during active");
        pushFrame(2'd1, 16'd4);
        doneCount = 0;
        applyStimulus(2'd1, 1'b1);
        waitHref();
        applyStimulus(2'd1, 1'b0);
        waitFrameDone();
        checkOutput("frame_count 5", 32'(frameCount), 5);
        vsyncSeen = 0;
        repeat (300) begin
            @(negedge clk);
            if (vsync === 1'b1) vsyncSeen++;
        end
        checkOutput("no restart vsync", vsyncSeen, 0);
        checkOutput("single frame_done", doneCount, 1);

        $display("[TB] reset mid-active");
        pushFrame(2'd0, 16'd5);
        applyStimulus(2'd0, 1'b1);
        waitHref();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        applyStimulus(2'd0, 1'b0);
        @(negedge clk);
        checkOutput("abort href", 32'(href), 0);
        checkOutput("abort d", 32'(d), 0);
        checkOutput("abort vsync", 32'(vsync), 0);
        checkOutput("abort frame_count", 32'(frameCount), 0);
        checkOutput("abort frame_done", 32'(frameDone), 0);
        expQ.delete();
        doneCount = 0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("no done after abort", doneCount, 0);
        pushFrame(2'd0, 16'd0);
        applyStimulus(2'd0, 1'b1);
        @(negedge clk);
        checkOutput("restart vsync", 32'(vsync), 1);
        applyStimulus(2'd0, 1'b0);
        waitFrameDone();
        checkOutput("restart frame_count", 32'(frameCount), 1);
        @(negedge clk);

        $display("[TB] frame count wrap and gradient");
        force dut.frameCount_q = 16'hFFFF;
        @(negedge clk);
        release dut.frameCount_q;
        @(negedge clk);
        checkOutput("preloaded count", 32'(frameCount), 32'h0000FFFF);
        pushFrame(2'd3, 16'hFFFF);
        applyStimulus(2'd3, 1'b1);
        @(negedge clk);
        applyStimulus(2'd3, 1'b0);
        waitFrameDone();
        checkOutput("count wrap", 32'(frameCount), 0);
        @(negedge clk);
        pushFrame(2'd3, 16'd0);
        applyStimulus(2'd3, 1'b1);
        @(negedge clk);
        applyStimulus(2'd3, 1'b0);
        waitFrameDone();
        checkOutput("count after wrap", 32'(frameCount), 1);
        checkOutput("gradient drained", 32'(expQ.size()), 0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
